// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scanner for a common-anode, active-low
// 7-segment display bank.
//
// Each digit owns a code entry in a shadow bank that the host writes freely.
// The whole shadow bank is copied to the active bank once per frame, so a
// frame never shows a half-updated set of digits. The active code of the
// current digit goes out to an external decoder. The decoder's pattern comes
// back, is registered, and drives the pins together with a one-hot-low anode.
// The first BLANK_CYCLES of every digit slot are fully dark so that the old
// digit's pattern does not ghost onto the new anode.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wr_en      shadow write strobe (one entry per cycle)
//   wr_addr    digit index to write; indices >= NUM_DIGITS are ignored
//   wr_data    [3:0] code, [4] digit enable, [5] decimal point (option only)
//   code_out   {4'h0, active code of the current digit} to the decoder
//   seg7_in    decoder pattern, active-low, bit0 = dp
//   seg_out    registered segments to the pins, active-low
//   an_out     registered anodes, active-low, one-hot-low or all high
//   frame_tick one-cycle pulse after each commit of shadow to active
//
// Build option: define SEG_SCAN_DP_EN to widen wr_data to 6 bits. Bit 5 is
// then a per-digit, double-buffered decimal-point flag that forces seg_out[0]
// low while that digit is driven.

module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
`ifdef SEG_SCAN_DP_EN
  input  logic [5:0]            wr_data,
`else
  input  logic [4:0]            wr_data,
`endif
  output logic [7:0]            code_out,
  input  logic [7:0]            seg7_in,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_out,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
`ifdef SEG_SCAN_DP_EN
  localparam int ENT_W = 6;
`else
  localparam int ENT_W = 5;
`endif

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_t;

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [ENT_W-1:0]      shadow [NUM_DIGITS];
  logic [ENT_W-1:0]      active [NUM_DIGITS];

  phase_t                phase;
  logic                  slot_end;
  logic                  frame_end;
  logic                  wr_hit;
  logic                  lit;
  logic [ENT_W-1:0]      cur;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign cur       = active[digit_idx];
  assign code_out  = {4'h0, cur[3:0]};
  assign slot_end  = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign wr_hit    = wr_en && (32'(wr_addr) < NUM_DIGITS);

  always_comb begin
    phase    = (slot_cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
    lit      = (phase == PH_DRIVE) && cur[4];
    seg_next = lit ? seg7_in : 8'hFF;
`ifdef SEG_SCAN_DP_EN
    if (lit && cur[5]) seg_next[0] = 1'b0;
`endif
    an_next  = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (i == 32'(digit_idx))) an_next[i] = 1'b0;
    end
  end

  // The output register sees the same (slot_cnt, digit_idx) that produced
  // seg_next, so pins lag the scan state by exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      seg_out    <= '1;
      an_out     <= '1;
      frame_tick <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) digit_idx <= frame_end ? '0 : digit_idx + 1'b1;

      // A write on the commit edge lands in shadow only; active takes the
      // pre-edge shadow contents.
      if (wr_hit) shadow[wr_addr[IDX_W-1:0]] <= wr_data;
      if (frame_end) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
      end

      frame_tick <= frame_end;
      seg_out    <= seg_next;
      an_out     <= an_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Drives directed writes, pushes the expected pin state of every cycle into
// a queue, and a monitor pops and compares on each sample point. A hex
// 7-segment decoder model closes the code_out -> seg7_in loop.

module tb_seg_scan_mux;

`ifdef SEG_SCAN_DP_EN
  localparam int DW = 6;
`else
  localparam int DW = 5;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    code_out;
  logic [7:0]    seg7_in;
  logic [7:0]    seg_out;
  logic [3:0]    an_out;
  logic          frame_tick;

  seg_scan_mux #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .code_out  (code_out),
    .seg7_in   (seg7_in),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hex decoder: active-low, bit7=a .. bit1=g, bit0=dp (off).
  function automatic logic [7:0] hex7(input logic [3:0] c);
    case (c)
      4'h0: hex7 = 8'h03; 4'h1: hex7 = 8'h9F; 4'h2: hex7 = 8'h25; 4'h3: hex7 = 8'h0D;
      4'h4: hex7 = 8'h99; 4'h5: hex7 = 8'h49; 4'h6: hex7 = 8'h41; 4'h7: hex7 = 8'h1F;
      4'h8: hex7 = 8'h01; 4'h9: hex7 = 8'h09; 4'hA: hex7 = 8'h11; 4'hB: hex7 = 8'hC1;
      4'hC: hex7 = 8'h63; 4'hD: hex7 = 8'h85; 4'hE: hex7 = 8'h61; default: hex7 = 8'h71;
    endcase
  endfunction

  always_comb seg7_in = hex7(code_out[3:0]);

  typedef struct {
    int         k;
    logic [7:0] seg;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   k      = 0;   // posedges since the latest reset release
  int   run    = 0;

  // Per-frame digit patterns (8'hFF = dark digit). Frame f spans edges
  // 32f+1 .. 32f+32 and shows the bank committed on edge 32f.
  logic [7:0] tab0 [6][4];
  logic [7:0] tab1 [3][4];

  initial begin
    tab0[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tab0[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tab0[2] = '{8'h9F, 8'h25, 8'h0D, 8'h99};
    tab0[3] = '{8'h9F, 8'h25, 8'hFF, 8'h99};
    tab0[4] = '{8'h9F, 8'h25, 8'hFF, 8'h99};
    tab0[5] = '{8'h9F, 8'h61, 8'hFF, 8'h99};
    tab1[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef SEG_SCAN_DP_EN
    tab1[1] = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    tab1[2] = '{8'h01, 8'hFF, 8'hFF, 8'hFF};
`else
    tab1[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tab1[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
  end

  task automatic push_reset_exp();
    exp_t e;
    e.k = -1; e.seg = 8'hFF; e.an = 4'hF; e.tick = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_exp();
    exp_t e;
    int f, p, s, d;
    logic [7:0] pat;
    f = (k - 1) / 32;
    p = (k - 1) % 32;
    s = p % 8;
    d = p / 8;
    pat = (run == 0) ? tab0[f][d] : tab1[f][d];
    e.k = k;
    e.seg = 8'hFF;
    e.an = 4'hF;
    if (s >= 2 && pat != 8'hFF) begin
      e.seg = pat;
      e.an[d] = 1'b0;
    end
    e.tick = (k % 32 == 0);
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    push_exp();
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = DW'(d);
    step();
    wr_en   = 1'b0;
  endtask

  // Monitor: wakes on every falling clock and on reset assertion so that the
  // asynchronous reset response is sampled before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (seg_out === e.seg && an_out === e.an && frame_tick === e.tick)
          n_pass++;
        else
          $display("FAIL pins@k=%0d run=%0d: got seg=%h an=%b tick=%b, want seg=%h an=%b tick=%b",
                   e.k, run, seg_out, an_out, frame_tick, e.seg, e.an, e.tick);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    // Reset state.
    @(posedge clk); #1;
    push_reset_exp();
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Frames 0/1 dark; load digits 1,2,3,4 on edges 41..44.
    run_to(40);
    wr(3'd0, 6'h11);
    wr(3'd1, 6'h12);
    wr(3'd2, 6'h13);
    wr(3'd3, 6'h14);
    // Disable digit 2 during frame 2.
    run_to(70);
    wr(3'd2, 6'h08);
    // Write on the commit edge 128: visible only from frame 5.
    run_to(127);
    wr(3'd1, 6'h1E);
    // Out-of-range address is ignored.
    run_to(140);
    wr(3'd5, 6'h1F);
    // Reset asserted mid-DRIVE of digit 3.
    run_to(189);
    @(negedge clk); #2;
    push_reset_exp();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    k   = 0;
    run = 1;

    // Shadow was cleared by reset: frames stay dark.
`ifdef SEG_SCAN_DP_EN
    run_to(1);
    wr(3'd0, 6'h38);
    run_to(39);
    wr(3'd0, 6'h18);
    run_to(96);
`else
    run_to(48);
`endif

    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
